// File: rtl/video_test_pattern_gen_pkg.sv
// Shared timing defaults, pattern encodings and helper functions for the test pattern generator.
// The 720p totals here are the line/frame widths downstream stages (rank_transform) must agree with.
package video_test_pattern_gen_pkg;

  localparam int DEF_H_ACTIVE = 1280;
  localparam int DEF_H_FP     = 110;
  localparam int DEF_H_SYNC   = 40;
  localparam int DEF_H_BP     = 220;
  localparam int DEF_V_ACTIVE = 720;
  localparam int DEF_V_FP     = 5;
  localparam int DEF_V_SYNC   = 5;
  localparam int DEF_V_BP     = 20;

  localparam int TOTAL_LINE_W  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int TOTAL_FRAME_H = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Galois form of x^16+x^14+x^13+x^11+1, shifting right
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    PAT_H_RAMP  = 2'd0,
    PAT_V_RAMP  = 2'd1,
    PAT_CHECKER = 2'd2,
    PAT_SOLID   = 2'd3
  } pattern_e;

  function automatic int clog2_fn(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] state);
    return state[0] ? ((state >> 1) ^ LFSR_TAPS) : (state >> 1);
  endfunction

endpackage

// File: rtl/video_timing_counter.sv
// Free-running h/v raster counters with combinational de/sync decode and frame wrap flags.
// All decode outputs describe the current counter state; the parent registers them.
module video_timing_counter
  import video_test_pattern_gen_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int H_W     = clog2_fn(H_TOTAL),
  localparam int V_W     = clog2_fn(V_TOTAL)
) (
  input  logic           clk,
  input  logic           rst,
  output logic [H_W-1:0] o_h_cnt,
  output logic [V_W-1:0] o_v_cnt,
  output logic           o_de,
  output logic           o_h_sync,
  output logic           o_v_sync,
  output logic           o_frame_first,
  output logic           o_frame_last
);

  logic [H_W-1:0] r_h_cnt;
  logic [V_W-1:0] r_v_cnt;
  logic           w_h_last;
  logic           w_v_last;

  assign w_h_last = (r_h_cnt == H_W'(H_TOTAL - 1));
  assign w_v_last = (r_v_cnt == V_W'(V_TOTAL - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_last) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  // Sync windows sit after the front porch; v_sync spans whole lines, so it flips at h_cnt=0
  assign o_h_sync      = (r_h_cnt >= H_W'(H_ACTIVE + H_FP)) && (r_h_cnt < H_W'(H_ACTIVE + H_FP + H_SYNC));
  assign o_v_sync      = (r_v_cnt >= V_W'(V_ACTIVE + V_FP)) && (r_v_cnt < V_W'(V_ACTIVE + V_FP + V_SYNC));
  assign o_de          = (r_h_cnt < H_W'(H_ACTIVE)) && (r_v_cnt < V_W'(V_ACTIVE));
  assign o_frame_first = (r_h_cnt == '0) && (r_v_cnt == '0);
  assign o_frame_last  = w_h_last && w_v_last;
  assign o_h_cnt       = r_h_cnt;
  assign o_v_cnt       = r_v_cnt;

endmodule

// File: rtl/video_test_pattern_gen.sv
// Synthetic video source: raster timing plus an 8-bit luma test pattern, all outputs registered.
// Define TPG_LFSR_NOISE_EN to turn pattern 3 into LFSR texture instead of a solid level.
module video_test_pattern_gen
  import video_test_pattern_gen_pkg::*;
#(
  parameter int H_ACTIVE         = DEF_H_ACTIVE,
  parameter int H_FP             = DEF_H_FP,
  parameter int H_SYNC           = DEF_H_SYNC,
  parameter int H_BP             = DEF_H_BP,
  parameter int V_ACTIVE         = DEF_V_ACTIVE,
  parameter int V_FP             = DEF_V_FP,
  parameter int V_SYNC           = DEF_V_SYNC,
  parameter int V_BP             = DEF_V_BP,
  parameter bit SYNC_ACTIVE_HIGH = 1'b1,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int H_W     = clog2_fn(H_TOTAL),
  localparam int V_W     = clog2_fn(V_TOTAL)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     pattern_sel,
  input  logic [7:0]     solid_value,
  output logic           clk_out,
  output logic           de_out,
  output logic           h_sync_out,
  output logic           v_sync_out,
  output logic [7:0]     pixel_out,
  output logic           frame_start,
  output logic [H_W-1:0] col_out,
  output logic [V_W-1:0] row_out
);

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 || H_ACTIVE > H_TOTAL) begin : g_bad_timing
    $error("video_test_pattern_gen: every H_*/V_* must be >= 1 and H_ACTIVE <= H_TOTAL");
  end

  localparam logic SYNC_ON = SYNC_ACTIVE_HIGH;

  logic [H_W-1:0] w_h_cnt;
  logic [V_W-1:0] w_v_cnt;
  logic           w_de;
  logic           w_h_sync;
  logic           w_v_sync;
  logic           w_frame_first;
  logic           w_frame_last;

  video_timing_counter #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_timing (
    .clk           (clk),
    .rst           (rst),
    .o_h_cnt       (w_h_cnt),
    .o_v_cnt       (w_v_cnt),
    .o_de          (w_de),
    .o_h_sync      (w_h_sync),
    .o_v_sync      (w_v_sync),
    .o_frame_first (w_frame_first),
    .o_frame_last  (w_frame_last)
  );

  logic [1:0] r_pat_sel;
  logic [1:0] w_pat_sel;
  logic [7:0] r_frame_cnt;
  logic [7:0] w_col8;
  logic [7:0] w_row8;
  logic [7:0] w_pat3;
  logic [7:0] w_pixel;

  // The first pixel of a frame already uses the freshly sampled controls, so no frame is torn
  assign w_pat_sel = w_frame_first ? pattern_sel : r_pat_sel;
  assign w_col8    = 8'(w_h_cnt);
  assign w_row8    = 8'(w_v_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pat_sel   <= 2'd0;
      r_frame_cnt <= 8'd0;
    end else begin
      if (w_frame_first) r_pat_sel <= pattern_sel;
      if (w_frame_last)  r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

`ifdef TPG_LFSR_NOISE_EN
  logic [15:0] r_lfsr;
  logic [15:0] w_lfsr_cur;

  // Reload at frame start so every frame carries the identical texture
  assign w_lfsr_cur = w_frame_first ? LFSR_SEED : r_lfsr;
  assign w_pat3     = w_lfsr_cur[7:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= LFSR_SEED;
    end else if (w_de) begin
      r_lfsr <= lfsr_step(w_lfsr_cur);
    end
  end
`else
  logic [7:0] r_solid;

  assign w_pat3 = w_frame_first ? solid_value : r_solid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_solid <= 8'd0;
    end else if (w_frame_first) begin
      r_solid <= solid_value;
    end
  end
`endif

  always_comb begin
    w_pixel = 8'h00;
    case (pattern_e'(w_pat_sel))
      PAT_H_RAMP:  w_pixel = w_col8 + r_frame_cnt;
      PAT_V_RAMP:  w_pixel = w_row8;
      PAT_CHECKER: w_pixel = (w_col8[3] ^ w_row8[3]) ? 8'hFF : 8'h00;
      PAT_SOLID:   w_pixel = w_pat3;
      default:     w_pixel = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      de_out      <= 1'b0;
      h_sync_out  <= ~SYNC_ON;
      v_sync_out  <= ~SYNC_ON;
      pixel_out   <= 8'h00;
      frame_start <= 1'b0;
      col_out     <= '0;
      row_out     <= '0;
    end else begin
      de_out      <= w_de;
      h_sync_out  <= w_h_sync ? SYNC_ON : ~SYNC_ON;
      v_sync_out  <= w_v_sync ? SYNC_ON : ~SYNC_ON;
      pixel_out   <= w_de ? w_pixel : 8'h00;
      frame_start <= w_frame_first;
      col_out     <= w_h_cnt;
      row_out     <= w_v_cnt;
    end
  end

  assign clk_out = clk;

endmodule

// File: tb/tb_video_test_pattern_gen.sv
// Self-checking bench: per-frame vector table plus a cycle-level scoreboard for a scaled raster,
// and a second instance with tiny inverted-sync timing.
module tb_video_test_pattern_gen;

  localparam int HA = 32, HFP = 4, HS = 4, HBP = 6, HT = HA + HFP + HS + HBP;
  localparam int VA = 20, VFP = 2, VS = 3, VBP = 4, VT = VA + VFP + VS + VBP;
  localparam int FRAME_A = HT * VT;
  localparam int NVEC = 11;
`ifdef TPG_LFSR_NOISE_EN
  localparam logic [7:0] PAT3_EXP = 8'hE1;
`else
  localparam logic [7:0] PAT3_EXP = 8'h5A;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] pattern_sel = 2'd0;
  logic [7:0] solid_value = 8'd0;

  logic       clk_out_a, de_a, hs_a, vs_a, fs_a;
  logic [7:0] px_a;
  logic [5:0] col_a;
  logic [4:0] row_a;
  logic       clk_out_b, de_b, hs_b, vs_b, fs_b;
  logic [7:0] px_b;
  logic [3:0] col_b;
  logic [2:0] row_b;

  int errors = 0;
  int checks = 0;
  bit b_done = 1'b0;

  always #5 clk = ~clk;

  video_test_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_ACTIVE_HIGH(1'b1)
  ) dut_a (
    .clk(clk), .rst(rst), .pattern_sel(pattern_sel), .solid_value(solid_value),
    .clk_out(clk_out_a), .de_out(de_a), .h_sync_out(hs_a), .v_sync_out(vs_a),
    .pixel_out(px_a), .frame_start(fs_a), .col_out(col_a), .row_out(row_a)
  );

  video_test_pattern_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_ACTIVE_HIGH(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst), .pattern_sel(pattern_sel), .solid_value(solid_value),
    .clk_out(clk_out_b), .de_out(de_b), .h_sync_out(hs_b), .v_sync_out(vs_b),
    .pixel_out(px_b), .frame_start(fs_b), .col_out(col_b), .row_out(row_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // ---------------- scoreboard: predictor at posedge, monitor at negedge ----------------
  typedef struct {
    logic       de, hs, vs, fs;
    logic [7:0] px;
    int         col, row;
  } exp_t;

  exp_t sb_q[$];
  int   sb_bad = 0;
  int   sb_frame = 0;
  int   sb_cycles = 0;
  int   sb_bad_col = -1, sb_bad_row = -1, sb_bad_px = -1, sb_bad_exp = -1;

  task automatic close_stream_frame();
    chk($sformatf("stream frame %0d cycle mismatches (first at col %0d row %0d px %0d exp %0d)",
                  sb_frame, sb_bad_col, sb_bad_row, sb_bad_px, sb_bad_exp), sb_bad, 0);
    sb_frame++;
    sb_bad = 0;
    sb_cycles = 0;
  endtask

  initial begin : predictor
    int mh, mv, mfc;
    logic [1:0] msel;
    logic [7:0] msolid;
`ifdef TPG_LFSR_NOISE_EN
    logic [15:0] mlfsr;
`endif
    exp_t e;
    mh = 0; mv = 0; mfc = 0; msel = 2'd0; msolid = 8'd0;
    forever begin
      @(posedge clk);
      if (rst) begin
        e = '{de: 1'b0, hs: 1'b0, vs: 1'b0, fs: 1'b0, px: 8'h00, col: 0, row: 0};
        mh = 0; mv = 0; mfc = 0; msel = 2'd0; msolid = 8'd0;
      end else begin
        if (mh == 0 && mv == 0) begin
          msel = pattern_sel;
          msolid = solid_value;
`ifdef TPG_LFSR_NOISE_EN
          mlfsr = 16'hACE1;
`endif
        end
        e.de  = (mh < HA) && (mv < VA);
        e.hs  = (mh >= HA + HFP) && (mh < HA + HFP + HS);
        e.vs  = (mv >= VA + VFP) && (mv < VA + VFP + VS);
        e.fs  = (mh == 0) && (mv == 0);
        e.col = mh;
        e.row = mv;
        case (msel)
          2'd0: e.px = 8'((mh + mfc) % 256);
          2'd1: e.px = 8'(mv % 256);
          2'd2: e.px = (((mh / 8) % 2) != ((mv / 8) % 2)) ? 8'hFF : 8'h00;
`ifdef TPG_LFSR_NOISE_EN
          default: e.px = mlfsr[7:0];
`else
          default: e.px = msolid;
`endif
        endcase
        if (!e.de) e.px = 8'h00;
`ifdef TPG_LFSR_NOISE_EN
        if (e.de) mlfsr = mlfsr[0] ? ((mlfsr >> 1) ^ 16'hB400) : (mlfsr >> 1);
`endif
        if (mh == HT - 1 && mv == VT - 1) mfc = (mfc + 1) % 256;
        if (mh == HT - 1) begin
          mh = 0;
          mv = (mv == VT - 1) ? 0 : mv + 1;
        end else begin
          mh = mh + 1;
        end
      end
      sb_q.push_back(e);
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (e.fs && sb_cycles > 0) close_stream_frame();
        if (de_a !== e.de || hs_a !== e.hs || vs_a !== e.vs || fs_a !== e.fs ||
            px_a !== e.px || int'(col_a) != e.col || int'(row_a) != e.row) begin
          if (sb_bad == 0) begin
            sb_bad_col = e.col; sb_bad_row = e.row;
            sb_bad_px = int'(px_a); sb_bad_exp = int'(e.px);
          end
          sb_bad++;
        end
        sb_cycles++;
      end
    end
  end

  // ---------------- small inverted-sync instance ----------------
  initial begin : b_check
    int cnt, de_cnt, hs_cnt, vs_cnt, hs_col, vs_row;
    wait (rst == 1'b0);
    @(negedge clk);
    chk("B first frame_start", int'(fs_b), 1);
    cnt = 0; de_cnt = 0; hs_cnt = 0; vs_cnt = 0; hs_col = -1; vs_row = -1;
    do begin
      if (de_b) de_cnt++;
      if (!hs_b) begin hs_cnt++; if (hs_col < 0) hs_col = int'(col_b); end
      if (!vs_b) begin vs_cnt++; if (vs_row < 0) vs_row = int'(row_b); end
      @(negedge clk);
      cnt++;
    end while (!fs_b && cnt < 200);
    chk("B frame length", cnt, 14 * 7);
    chk("B de count", de_cnt, 8 * 4);
    chk("B h_sync low count", hs_cnt, 2 * 7);
    chk("B h_sync first col", hs_col, 10);
    chk("B v_sync low count", vs_cnt, 14);
    chk("B v_sync first row", vs_row, 5);
    b_done = 1'b1;
  end

  // ---------------- main sequence ----------------
  typedef struct {
    logic [1:0] sel;
    logic [7:0] solid;
    int         pc, pr;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[NVEC];

  initial begin : main
    int cnt, de_cnt, hs_cnt, vs_cnt, hs_col, vs_row, probe;
    // frame i after reset runs with frame_cnt = i
    tbl[0]  = '{2'd0, 8'h00, 10, 0,  8'd10};
    tbl[1]  = '{2'd0, 8'h00, 10, 0,  8'd11};
    tbl[2]  = '{2'd0, 8'h00, 10, 0,  8'd12};
    tbl[3]  = '{2'd0, 8'h00, 31, 5,  8'd34};
    tbl[4]  = '{2'd1, 8'h00, 7,  13, 8'd13};
    tbl[5]  = '{2'd2, 8'h00, 8,  19, 8'hFF};
    tbl[6]  = '{2'd1, 8'h00, 5,  17, 8'd17};
    tbl[7]  = '{2'd2, 8'h00, 0,  8,  8'hFF};
    tbl[8]  = '{2'd3, 8'h5A, 0,  0,  PAT3_EXP};
    tbl[9]  = '{2'd3, 8'h5A, 0,  0,  PAT3_EXP};
    tbl[10] = '{2'd0, 8'h00, 0,  0,  8'd10};

    repeat (3) @(negedge clk);
    chk("reset de_out", int'(de_a), 0);
    chk("reset pixel_out", int'(px_a), 0);
    chk("reset h_sync", int'(hs_a), 0);
    chk("reset v_sync", int'(vs_a), 0);
    chk("reset frame_start", int'(fs_a), 0);
    chk("reset col/row", int'(col_a) + int'(row_a), 0);
    chk("B reset h_sync (inverted)", int'(hs_b), 1);
    chk("B reset v_sync (inverted)", int'(vs_b), 1);

    pattern_sel = tbl[0].sel;
    solid_value = tbl[0].solid;
    rst = 1'b0;
    @(negedge clk);
    chk("first de_out", int'(de_a), 1);
    chk("first frame_start", int'(fs_a), 1);

    for (int i = 0; i < NVEC; i++) begin
      cnt = 0; de_cnt = 0; hs_cnt = 0; vs_cnt = 0; hs_col = -1; vs_row = -1; probe = -1;
      do begin
        if (de_a) de_cnt++;
        if (hs_a) begin hs_cnt++; if (hs_col < 0) hs_col = int'(col_a); end
        if (vs_a) begin vs_cnt++; if (vs_row < 0) vs_row = int'(row_a); end
        if (int'(col_a) == tbl[i].pc && int'(row_a) == tbl[i].pr) probe = int'(px_a);
        // controls change mid-frame; they must only land at the next frame start
        if (int'(row_a) == 10 && int'(col_a) == 0 && i + 1 < NVEC) begin
          pattern_sel = tbl[i + 1].sel;
          solid_value = tbl[i + 1].solid;
        end
        @(negedge clk);
        cnt++;
      end while (!fs_a && cnt < 2 * FRAME_A);
      chk($sformatf("vec%0d sel=%0d pixel(%0d,%0d)", i, tbl[i].sel, tbl[i].pc, tbl[i].pr),
          probe, int'(tbl[i].exp));
      chk($sformatf("vec%0d frame length", i), cnt, FRAME_A);
      if (i == 0) begin
        chk("de count", de_cnt, HA * VA);
        chk("h_sync count", hs_cnt, HS * VT);
        chk("h_sync first col", hs_col, HA + HFP);
        chk("v_sync count", vs_cnt, VS * HT);
        chk("v_sync first row", vs_row, VA + VFP);
      end
    end

    // reset pulse mid-frame
    cnt = 0;
    while (!(int'(col_a) == 25 && int'(row_a) == 12) && cnt < 2 * FRAME_A) begin
      @(negedge clk);
      cnt++;
    end
    chk("reached (25,12)", int'(col_a == 6'd25 && row_a == 5'd12), 1);
    chk("pixel before rst", int'(px_a), 25 + 11);
    rst = 1'b1;
    @(negedge clk);
    chk("mid-rst de_out", int'(de_a), 0);
    chk("mid-rst pixel_out", int'(px_a), 0);
    chk("mid-rst col/row", int'(col_a) + int'(row_a), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post-rst frame_start", int'(fs_a), 1);
    chk("post-rst de_out", int'(de_a), 1);
    chk("post-rst col/row", int'(col_a) + int'(row_a), 0);
    chk("post-rst pixel (frame_cnt 0)", int'(px_a), 0);
    repeat (10) @(negedge clk);
    chk("post-rst pixel(10,0)", int'(px_a), 10);

    cnt = 0;
    while (!fs_a && cnt < 2 * FRAME_A) begin
      @(negedge clk);
      cnt++;
    end
    chk("post-rst next frame_start", int'(fs_a), 1);

    cnt = 0;
    while (!b_done && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
    chk("B sequence completed", int'(b_done), 1);

    close_stream_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
